// File: rtl/muldiv_if.sv
// Handshake/data bundle between the core pipeline and the multiply/divide unit.
// master: start, op, data1, data2, hi_we, lo_we, wdata -> ; <- busy, done, hi, lo
// slave : the reverse directions, used by muldiv.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, data1, data2, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, data1, data2, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle,
// 32 steps per operation; operands are taken as magnitudes and the signs are
// re-applied when the result is written.
// Ports: clk, rst_n (async active-low), bus (muldiv_if.slave):
//   start/op/data1/data2 request, hi_we/lo_we/wdata mthi/mtlo writes,
//   busy/done status, hi/lo result registers.
module muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int unsigned DW = 2 * WIDTH;
    // Counter must be able to hold WIDTH itself, i.e. "all steps completed".
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;          // |multiplicand| or |dividend|
    logic [WIDTH-1:0] b_q, b_d;          // |multiplier| or |divisor|
    logic             sign1_q, sign1_d;
    logic             sign2_q, sign2_d;
    logic             dz_q, dz_d;        // divide by zero: result preloaded in work
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    work_q, work_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Operand magnitudes at request time; only signed ops take absolute values.
    logic             req_signed;
    logic             req_s1, req_s2;
    logic [WIDTH-1:0] req_a, req_b;

    assign req_signed = ~bus.op[0];
    assign req_s1     = req_signed & bus.data1[WIDTH-1];
    assign req_s2     = req_signed & bus.data2[WIDTH-1];
    assign req_a      = req_s1 ? WIDTH'({WIDTH{1'b0}} - bus.data1) : bus.data1;
    assign req_b      = req_s2 ? WIDTH'({WIDTH{1'b0}} - bus.data2) : bus.data2;

    // Multiply step: add multiplicand into upper half when the low bit is set.
    logic [WIDTH:0]   mul_sum;
    assign mul_sum = {1'b0, work_q[DW-1:WIDTH]} + {1'b0, a_q};

    // Divide step: trial subtract of divisor from the shifted partial remainder;
    // the top bit is the borrow (remainder stays as is when set).
    logic [WIDTH:0]   div_trial;
    assign div_trial = work_q[DW-1:WIDTH-1] - {1'b0, b_q};

    // Sign fix-up of the finished results.
    logic             op_signed;
    logic [DW-1:0]    prod_res;
    logic [WIDTH-1:0] quot_res, rem_res;

    assign op_signed = ~op_q[0];
    assign prod_res  = (op_signed & (sign1_q ^ sign2_q)) ? DW'({DW{1'b0}} - work_q) : work_q;
    assign quot_res  = (op_signed & (sign1_q ^ sign2_q)) ?
                       WIDTH'({WIDTH{1'b0}} - work_q[WIDTH-1:0]) : work_q[WIDTH-1:0];
    assign rem_res   = (op_signed & sign1_q) ?
                       WIDTH'({WIDTH{1'b0}} - work_q[DW-1:WIDTH]) : work_q[DW-1:WIDTH];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            a_q     <= '0;
            b_q     <= '0;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            work_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign1_q <= sign1_d;
            sign2_q <= sign2_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        sign1_d = sign1_q;
        sign2_d = sign2_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // mthi/mtlo; a result accepted in the same cycle overwrites later.
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = req_a;
                    b_d     = req_b;
                    sign1_d = req_s1;
                    sign2_d = req_s2;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    if (bus.op[1] && (bus.data2 == '0)) begin
                        dz_d    = 1'b1;
                        work_d  = {bus.data1, {WIDTH{1'b1}}};
                        state_d = FINISH;
                    end else begin
                        dz_d    = 1'b0;
                        work_d  = bus.op[1] ? {{WIDTH{1'b0}}, req_a} : {{WIDTH{1'b0}}, req_b};
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!op_q[1]) begin
                        work_d = work_q[0] ? {mul_sum, work_q[WIDTH-1:1]}
                                           : {1'b0, work_q[DW-1:1]};
                    end else begin
                        work_d = div_trial[WIDTH] ? {work_q[DW-2:0], 1'b0}
                                                  : {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (dz_q) begin
                    hi_d = work_q[DW-1:WIDTH];
                    lo_d = work_q[WIDTH-1:0];
                end else if (!op_q[1]) begin
                    hi_d = prod_res[DW-1:WIDTH];
                    lo_d = prod_res[WIDTH-1:0];
                end else begin
                    hi_d = rem_res;
                    lo_d = quot_res;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv with an expected-result scoreboard.
module tb_muldiv;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model: {hi, lo} for each op.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] d1,
                                          input logic [31:0] d2);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(d1));
        sb = longint'($signed(d2));
        ua = {32'h0, d1};
        ub = {32'h0, d2};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (d2 == 32'h0) return {d1, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (d2 == 32'h0) return {d1, 32'hFFFFFFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Issue one operation, wait for done, and compare against the scoreboard.
    // At cycle intf (if >= 0) a second start plus an mthi write is attempted.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [63:0] expv, input int lat,
                          input int intf, output logic [31:0] hi_e0);
        logic [31:0] pre_hi, pre_lo;
        int          k, busy_cnt, unstable;
        exp_t        e;
        sbq.push_back('{expv[63:32], expv[31:0], lat});
        bus.start = 1'b1;
        bus.op    = op;
        bus.data1 = d1;
        bus.data2 = d2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        pre_hi    = bus.hi;
        pre_lo    = bus.lo;
        hi_e0     = bus.hi;
        busy_cnt  = bus.busy ? 1 : 0;
        k         = 0;
        unstable  = 0;
        while (k < 80) begin
            if (k == intf) begin
                bus.start = 1'b1;
                bus.op    = 2'b01;
                bus.data1 = 32'd9;
                bus.data2 = 32'd9;
                bus.hi_we = 1'b1;
                bus.wdata = 32'hDEADBEEF;
            end else begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
            if (bus.done) break;
            if (bus.busy) busy_cnt++;
            if (bus.hi !== pre_hi || bus.lo !== pre_lo) unstable++;
        end
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        e = sbq.pop_front();
        check({tag, " latency"}, 64'(k), 64'(e.lat));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(e.lat));
        check({tag, " hi/lo"}, {bus.hi, bus.lo}, {e.hi, e.lo});
        check({tag, " hi/lo stable while busy"}, 64'(unstable), 64'd0);
        @(posedge clk);
        #1;
        check({tag, " done/busy after pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
        check({tag, " hi/lo held"}, {bus.hi, bus.lo}, {e.hi, e.lo});
    endtask

    initial begin
        logic [31:0] h0;
        int          pulses;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.data1 = '0;
        bus.data2 = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // mthi / mtlo while idle
        bus.hi_we = 1'b1; bus.wdata = 32'h11111111;
        @(posedge clk); #1; bus.hi_we = 1'b0;
        check("mthi", {bus.hi, bus.lo}, {32'h11111111, 32'h0});
        bus.lo_we = 1'b1; bus.wdata = 32'h22222222;
        @(posedge clk); #1; bus.lo_we = 1'b0;
        check("mtlo", {bus.hi, bus.lo}, {32'h11111111, 32'h22222222});
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h33333333;
        @(posedge clk); #1; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("mthi+mtlo", {bus.hi, bus.lo}, {32'h33333333, 32'h33333333});

        // Fixed vectors
        run_op("mult -3*5", 2'b00, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 34, -1, h0);
        run_op("multu max*max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 34, -1, h0);
        run_op("mult min*-1", 2'b00, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, -1, h0);
        run_op("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, -1, h0);
        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 34, -1, h0);
        run_op("divu 1234/0", 2'b11, 32'd1234, 32'd0, 64'h000004D2_FFFFFFFF, 1, -1, h0);
        run_op("div -7/0", 2'b10, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 1, -1, h0);

        // Model-derived vectors
        run_op("mult -7*-9", 2'b00, 32'hFFFFFFF9, 32'hFFFFFFF7, model(2'b00, 32'hFFFFFFF9, 32'hFFFFFFF7), 34, -1, h0);
        run_op("multu mixed", 2'b01, 32'h12345678, 32'h9ABCDEF0, model(2'b01, 32'h12345678, 32'h9ABCDEF0), 34, -1, h0);
        run_op("mult mixed", 2'b00, 32'h87654321, 32'h0FEDCBA9, model(2'b00, 32'h87654321, 32'h0FEDCBA9), 34, -1, h0);
        run_op("div min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, model(2'b10, 32'h80000000, 32'hFFFFFFFF), 34, -1, h0);
        run_op("div -100/7", 2'b10, 32'hFFFFFF9C, 32'd7, model(2'b10, 32'hFFFFFF9C, 32'd7), 34, -1, h0);
        run_op("div 100/-7", 2'b10, 32'd100, 32'hFFFFFFF9, model(2'b10, 32'd100, 32'hFFFFFFF9), 34, -1, h0);
        run_op("divu max/3", 2'b11, 32'hFFFFFFFF, 32'd3, model(2'b11, 32'hFFFFFFFF, 32'd3), 34, -1, h0);
        run_op("divu small/big", 2'b11, 32'd5, 32'hF0000000, model(2'b11, 32'd5, 32'hF0000000), 34, -1, h0);

        // Start together with mthi/mtlo: write lands first, result overwrites it
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hABCD0123;
        run_op("start+mt", 2'b11, 32'd1234, 32'd0, 64'h000004D2_FFFFFFFF, 1, -1, h0);
        check("start+mt write first", {32'h0, h0}, {32'h0, 32'hABCD0123});

        // Start and mthi while busy are ignored
        run_op("multu 3*4 ignore", 2'b01, 32'd3, 32'd4, 64'h00000000_0000000C, 34, 10, h0);

        // Reset in the middle of a divide
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5A5A5A5A;
        @(posedge clk); #1; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.start = 1'b1; bus.op = 2'b10; bus.data1 = 32'd1000; bus.data2 = 32'd3;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("busy before reset", {63'd0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid-op reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
        check("mid-op reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) pulses++;
        end
        check("no activity after reset", 64'(pulses), 64'd0);
        run_op("divu after reset", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 34, -1, h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is required to be supported.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  in  1  request to begin an operation; sampled only while idle.
REQ-005 SHALL have port op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 SHALL have port data1  in  32  multiplicand / dividend (same operand bus the ALU receives).
REQ-007 SHALL have port data2  in  32  multiplier / divisor.
REQ-008 SHALL have port hi_we  in  1  mthi write enable.
REQ-009 SHALL have port lo_we  in  1  mtlo write enable.
REQ-010 SHALL have port wdata  in  32  data for mthi/mtlo.
REQ-011 SHALL have port busy  out  1  high while an operation is in progress.
REQ-012 SHALL have port done  out  1  one-cycle pulse; hi/lo hold the new result in that cycle.
REQ-013 SHALL have port hi  out  32  HI register (product upper half / remainder).
REQ-014 SHALL have port lo  out  32  LO register (product lower half / quotient).

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FINISH; IDLE->CALC on start; CALC->FINISH after the 32nd iteration; FINISH->IDLE unconditionally.
REQ-016 SHALL, on the edge sampling start=1 in IDLE, latch op, the absolute values of data1/data2 (signed ops) or raw values (unsigned ops), the operand sign bits and the op code, and clear a 6-bit iteration counter.
REQ-017 SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle in CALC, 32 steps total, using a 64-bit working register.
REQ-018 SHALL, on the FINISH edge, write hi/lo: multiply -> {hi,lo}=64-bit product, negated if signed and sign1^sign2; divide -> lo=quotient (negated if signed and sign1^sign2), hi=remainder (negated if signed and sign1).
REQ-019 SHALL assert done for exactly the one cycle after the FINISH edge, i.e. the cycle in which hi/lo first show the result; start sampled at edge E0 -> done high after edge E34.
REQ-020 SHALL drive busy=1 from the edge that accepts start up to, but not including, the cycle in which done is high.
REQ-021 SHALL ignore start while busy=1; latched operands and op SHALL NOT change.
REQ-022 SHALL, for div/divu with data2=0, skip CALC (IDLE->FINISH) and write hi=data1, lo=32'hFFFFFFFF; done high after edge E1.
REQ-023 SHALL, when idle, write wdata to hi on hi_we and to lo on lo_we at the next edge; both enables together write both.
REQ-024 SHALL ignore hi_we/lo_we while busy=1.
REQ-025 SHALL accept start and hi_we/lo_we in the same idle cycle: the write takes effect, and the later result overwrites it.
REQ-026 SHALL handle signed edge case 32'h80000000 correctly (magnitude as unsigned 2^31): mult 80000000*FFFFFFFF -> hi=00000000, lo=80000000.
REQ-027 SHALL keep hi/lo stable at all times except at the FINISH edge or an accepted mthi/mtlo write.

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-operation, immediately force state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, working registers=0.
REQ-029 SHALL NOT accept start on the first edge at which rst_n is already high but was low during that cycle's setup window; start is accepted from the following edge.

Verification
REQ-030 SHALL pass: mult data1=FFFFFFFD (-3), data2=5 -> done after E34, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-031 SHALL pass: multu FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001; busy high for exactly 34 cycles.
REQ-032 SHALL pass: div FFFFFFF9 (-7) / 2 -> lo=FFFFFFFD, hi=FFFFFFFF; divu 100/7 -> lo=0000000E, hi=00000002.
REQ-033 SHALL pass: divu 1234/0 -> done after E1, hi=000004D2, lo=FFFFFFFF.
REQ-034 SHALL pass: start multu 3*4, pulse start with 9*9 and hi_we=1 at cycle 10 -> both ignored; result hi=0, lo=0000000C.
REQ-035 SHALL pass: rst_n low at cycle 15 of a div -> busy=0, hi=lo=0 immediately; no done pulse; next start runs normally.
